// File: rtl/z80_bus_responder.sv
// Bus-side target for the A-Z80 pin interface: classifies each machine cycle,
// turns it into one backend req/ack transaction and stalls the CPU with nWAIT.
module z80_bus_responder #(
    parameter int unsigned MIN_WAIT  = 0,
    parameter int unsigned IO_ENABLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic        nWAIT,
    output logic        nINT,
    output logic        be_req,
    output logic        be_we,
    output logic        be_io,
    output logic [15:0] be_addr,
    output logic [7:0]  be_wdata,
    input  logic [7:0]  be_rdata,
    input  logic        be_ack,
    input  logic        irq_req,
    input  logic [7:0]  irq_vector
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_REQ,
        S_WAITX,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic        nwait_q, nwait_d;
    logic        nint_q, nint_d;
    logic        armed_q, armed_d;
    logic        doe_q, doe_d;
    logic [7:0]  dout_q, dout_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        io_q, io_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;

    logic io_en;
    logic inta;
    logic start;
    logic ack_evt;

    always_comb begin
        io_en = (IO_ENABLE != 0);
        inta  = !nIORQ && !nM1;
        start = (!nMREQ && nRFSH) || (io_en && !nIORQ && nM1) || inta;

        state_d = state_q;
        nwait_d = nwait_q;
        doe_d   = doe_q;
        dout_d  = dout_q;
        req_d   = req_q;
        we_d    = we_q;
        io_d    = io_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        ack_evt = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nwait_d = 1'b0;
                    state_d = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                // The vector is ready at once, so the acknowledge cycle is not stalled.
                if (inta) begin
                    dout_d  = irq_vector;
                    doe_d   = 1'b1;
                    nwait_d = 1'b1;
                    ack_evt = 1'b1;
                    state_d = S_HOLD;
                end else if ((!nRD || !nWR) && (nIORQ || io_en)) begin
                    addr_d  = A;
                    wdata_d = D_in;
                    we_d    = !nWR;
                    io_d    = !nIORQ;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end else if (nMREQ && nIORQ && nRD && nWR) begin
                    nwait_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (be_ack) begin
                    if (!we_q) begin
                        dout_d = be_rdata;
                        doe_d  = 1'b1;
                    end
                    req_d   = 1'b0;
                    cnt_d   = 4'(MIN_WAIT);
                    state_d = S_WAITX;
                end
            end
            S_WAITX: begin
                if (cnt_q == 4'd0) begin
                    nwait_d = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (nRD && nIORQ && nMREQ) begin
                    doe_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // armed_q records that irq_req has been low since the last acknowledge.
        armed_d = armed_q;
        if (!irq_req) begin
            armed_d = 1'b1;
        end else if (ack_evt) begin
            armed_d = 1'b0;
        end

        nint_d = nint_q;
        if (ack_evt || !irq_req) begin
            nint_d = 1'b1;
        end else if (armed_q && !inta && (state_q == S_IDLE || state_q == S_HOLD)) begin
            nint_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            nwait_q <= 1'b1;
            nint_q  <= 1'b1;
            armed_q <= 1'b1;
            doe_q   <= 1'b0;
            dout_q  <= 8'h00;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            nwait_q <= nwait_d;
            nint_q  <= nint_d;
            armed_q <= armed_d;
            doe_q   <= doe_d;
            dout_q  <= dout_d;
            req_q   <= req_d;
            we_q    <= we_d;
            io_q    <= io_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign D_out    = dout_q;
    assign D_oe     = doe_q;
    assign nWAIT    = nwait_q;
    assign nINT     = nint_q;
    assign be_req   = req_q;
    assign be_we    = we_q;
    assign be_io    = io_q;
    assign be_addr  = addr_q;
    assign be_wdata = wdata_q;

endmodule
